// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared fetch-stage state encoding and constants
package rv32i_pkg;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    FETCH_RESET = 3'd0,
    FETCH_REQ   = 3'd1,
    FETCH_WAIT  = 3'd2,
    FETCH_HOLD  = 3'd3,
    FETCH_TRAP  = 3'd4
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_next_gen.sv
// rtl/pc_next_gen.sv - next-PC selection and instruction-address alignment check
module pc_next_gen (
  input  logic [31:0] pc_i,
  input  logic        pc_sel_i,
  input  logic [31:0] alu_result_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  // Sequential successor wraps naturally at 2^32
  assign pc_plus4_o = pc_i + 32'd4;

  // Jump targets drop bit 0 the way JALR does; bit 1 can still be set
  assign next_pc_o = pc_sel_i ? {alu_result_i[31:1], 1'b0} : pc_plus4_o;

  // Without compressed instructions every fetch address must be word aligned
  assign misaligned_o = next_pc_o[1];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch stage with hold and trap
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_sel,
  input  logic [31:0] alu_result,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        misaligned
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         instr_valid_q;
  logic         misaligned_q;
  logic         imem_req_q;

  logic [31:0]  next_pc_d;
  logic         next_misaligned_d;

  pc_next_gen u_pc_next_gen (
    .pc_i         (pc_q),
    .pc_sel_i     (pc_sel),
    .alu_result_i (alu_result),
    .pc_plus4_o   (pc_plus4),
    .next_pc_o    (next_pc_d),
    .misaligned_o (next_misaligned_d)
  );

  // Fetch sequencer: state, PC, held instruction and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH_RESET;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      imem_req_q    <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH_RESET: begin
          // Any response still in flight from before reset is dropped here
          state_q    <= FETCH_REQ;
          imem_req_q <= 1'b1;
        end
        FETCH_REQ: begin
          if (imem_ready) begin
            imem_req_q <= 1'b0;
            if (imem_rvalid) begin
              state_q <= FETCH_HOLD;
              instr_q <= imem_rdata;
            end else begin
              state_q <= FETCH_WAIT;
            end
          end
        end
        FETCH_WAIT: begin
          if (imem_rvalid) begin
            state_q <= FETCH_HOLD;
            instr_q <= imem_rdata;
          end
        end
        FETCH_HOLD: begin
          if (advance) begin
            instr_valid_q <= 1'b0;
            if (next_misaligned_d) begin
              misaligned_q <= 1'b1;
              state_q      <= FETCH_TRAP;
            end else begin
              pc_q       <= next_pc_d;
              state_q    <= FETCH_REQ;
              imem_req_q <= 1'b1;
            end
          end else begin
            // Valid is published one cycle after the capture edge
            instr_valid_q <= 1'b1;
          end
        end
        FETCH_TRAP: begin
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          misaligned_q  <= 1'b1;
        end
        default: begin
          state_q    <= FETCH_RESET;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign misaligned  = misaligned_q;

endmodule
